// File: rtl/mem_wb_backend.sv
// ---------------------------------------------------------------------------
// mem_wb_backend
//   Back end of the 5-stage MIPS pipeline. It holds the EX/MEM register, the
//   word-addressed data memory, the MEM/WB register and the writeback mux.
//   A beq that resolves taken in MEM squashes the instruction being captured
//   from EX in the same cycle, so the wrong-path instruction never changes
//   memory or the register file.
//
// Ports
//   clk                pipeline clock, all state updates on the rising edge
//   rst                asynchronous active-low reset
//   ex_*               EX-stage results and control for the instruction in EX
//   mem_pcsrc          branch taken, IF selects mem_branch_target
//   mem_branch_target  registered branch target
//   mem_reg_write      EX/MEM RegWrite, for the forwarding unit
//   mem_write_reg      EX/MEM destination register, for the forwarding unit
//   mem_alu_result     EX/MEM ALU result, for the forwarding unit
//   wb_reg_write       register-file write enable (never set for $0)
//   wb_write_reg       register-file write address
//   wb_write_data      register-file write data
// ---------------------------------------------------------------------------
module mem_wb_backend #(
  parameter int DMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_zero,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_write_reg,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_branch,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_pcsrc,
  output logic [31:0] mem_branch_target,
  output logic        mem_reg_write,
  output logic [4:0]  mem_write_reg,
  output logic [31:0] mem_alu_result,
  output logic        wb_reg_write,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data
);

  // EX/MEM register fields
  logic        exmem_branch;
  logic        exmem_zero;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic        exmem_reg_write;
  logic        exmem_mem_to_reg;
  logic [31:0] exmem_alu_result;
  logic [31:0] exmem_store_data;
  logic [4:0]  exmem_write_reg;
  logic [31:0] exmem_branch_target;

  // MEM/WB register fields
  logic        memwb_reg_write;
  logic        memwb_mem_to_reg;
  logic [4:0]  memwb_write_reg;
  logic [31:0] memwb_alu_result;
  logic [31:0] memwb_read_data;

  // Data memory; contents are deliberately not reset
  logic [31:0]       dmem [DMEM_DEPTH];
  logic [ADDR_W-1:0] mem_idx;
  logic [31:0]       read_data;

  assign mem_pcsrc = exmem_branch & exmem_zero;

  // Byte bits [1:0] and everything above the word index are dropped, so
  // addresses alias modulo the memory depth.
  assign mem_idx   = exmem_alu_result[ADDR_W+1:2];
  assign read_data = dmem[mem_idx];

  // EX/MEM capture. While a taken branch sits in MEM the incoming
  // instruction is on the wrong path, so its side-effecting controls are
  // dropped; its data fields are still latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_branch        <= 1'b0;
      exmem_zero          <= 1'b0;
      exmem_mem_read      <= 1'b0;
      exmem_mem_write     <= 1'b0;
      exmem_reg_write     <= 1'b0;
      exmem_mem_to_reg    <= 1'b0;
      exmem_alu_result    <= '0;
      exmem_store_data    <= '0;
      exmem_write_reg     <= '0;
      exmem_branch_target <= '0;
    end else begin
      exmem_branch        <= ex_branch    & ~mem_pcsrc;
      exmem_mem_read      <= ex_mem_read  & ~mem_pcsrc;
      exmem_mem_write     <= ex_mem_write & ~mem_pcsrc;
      exmem_reg_write     <= ex_reg_write & ~mem_pcsrc;
      exmem_zero          <= ex_zero;
      exmem_mem_to_reg    <= ex_mem_to_reg;
      exmem_alu_result    <= ex_alu_result;
      exmem_store_data    <= ex_store_data;
      exmem_write_reg     <= ex_write_reg;
      exmem_branch_target <= ex_branch_target;
    end
  end

  // Store at the end of the MEM cycle. Reset clears exmem_mem_write
  // asynchronously, so a store whose edge falls inside reset is dropped
  // without rst appearing here.
  always_ff @(posedge clk) begin
    if (exmem_mem_write) begin
      dmem[mem_idx] <= exmem_store_data;
    end
  end

  // MEM/WB capture; the read data is zeroed for non-loads so writeback
  // never sees stale memory contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memwb_reg_write  <= 1'b0;
      memwb_mem_to_reg <= 1'b0;
      memwb_write_reg  <= '0;
      memwb_alu_result <= '0;
      memwb_read_data  <= '0;
    end else begin
      memwb_reg_write  <= exmem_reg_write;
      memwb_mem_to_reg <= exmem_mem_to_reg;
      memwb_write_reg  <= exmem_write_reg;
      memwb_alu_result <= exmem_alu_result;
      memwb_read_data  <= exmem_mem_read ? read_data : 32'h0;
    end
  end

  assign mem_branch_target = exmem_branch_target;
  assign mem_reg_write     = exmem_reg_write;
  assign mem_write_reg     = exmem_write_reg;
  assign mem_alu_result    = exmem_alu_result;

  assign wb_reg_write  = memwb_reg_write & (memwb_write_reg != 5'd0);
  assign wb_write_reg  = memwb_write_reg;
  assign wb_write_data = memwb_mem_to_reg ? memwb_read_data : memwb_alu_result;

endmodule

// File: tb/tb_mem_wb_backend.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_backend
//   Self-checking bench for mem_wb_backend: reset behaviour, a table of
//   directed instructions with hand-computed expectations, then random
//   instruction streams (with occasional mid-run resets) against an
//   instruction-level model of the pipeline back end.
// ---------------------------------------------------------------------------
module tb_mem_wb_backend;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [31:0] tgt;
    logic        br;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        wb_rw;
    logic [4:0]  wb_wr;
    logic [31:0] wb_data;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] ex_alu_result;
  logic        ex_zero;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic [31:0] ex_branch_target;
  logic        ex_branch;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        mem_pcsrc;
  logic [31:0] mem_branch_target;
  logic        mem_reg_write;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  int compared   = 0;
  int mismatched = 0;

  // Instruction-level model: which instruction occupies MEM and WB, whether
  // it was squashed, what its load returned, and the memory image.
  logic [31:0] mem_model [256];
  instr_t      mem_slot;
  logic        mem_kill;
  instr_t      wb_slot;
  logic        wb_kill;
  logic [31:0] wb_loaded;

  vec_t vecs [17];

  mem_wb_backend #(.DMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_alu_result     (ex_alu_result),
    .ex_zero           (ex_zero),
    .ex_store_data     (ex_store_data),
    .ex_write_reg      (ex_write_reg),
    .ex_branch_target  (ex_branch_target),
    .ex_branch         (ex_branch),
    .ex_mem_read       (ex_mem_read),
    .ex_mem_write      (ex_mem_write),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_to_reg     (ex_mem_to_reg),
    .mem_pcsrc         (mem_pcsrc),
    .mem_branch_target (mem_branch_target),
    .mem_reg_write     (mem_reg_write),
    .mem_write_reg     (mem_write_reg),
    .mem_alu_result    (mem_alu_result),
    .wb_reg_write      (wb_reg_write),
    .wb_write_reg      (wb_write_reg),
    .wb_write_data     (wb_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic instr_t mkInstr(input logic [31:0] alu, input logic zero,
                                     input logic [31:0] sd, input logic [4:0] wr,
                                     input logic [31:0] tgt, input logic br,
                                     input logic mr, input logic mw,
                                     input logic rw, input logic m2r);
    instr_t i;
    i.alu = alu; i.zero = zero; i.sd = sd; i.wr = wr; i.tgt = tgt;
    i.br = br; i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r;
    return i;
  endfunction

  function automatic instr_t nopInstr();
    return mkInstr(32'h0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int kind;
    i = mkInstr($urandom, 1'b0, $urandom, 5'($urandom_range(0, 31)), $urandom,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    kind = $urandom_range(0, 5);
    case (kind)
      0: begin i.rw = 1'b1; end
      1: begin i.mr = 1'b1; i.rw = 1'b1; i.m2r = 1'b1; end
      2: begin i.mw = 1'b1; end
      3: begin i.br = 1'b1; i.zero = 1'($urandom_range(0, 1)); end
      4: begin i.mr = 1'b1; i.mw = 1'b1; i.rw = 1'b1; i.m2r = 1'b1; end
      default: begin
        i.zero = 1'($urandom); i.br = 1'($urandom); i.mr = 1'($urandom);
        i.mw = 1'($urandom); i.rw = 1'($urandom); i.m2r = 1'($urandom);
      end
    endcase
    return i;
  endfunction

  task automatic applyStimulus(input instr_t i);
    ex_alu_result    = i.alu;
    ex_zero          = i.zero;
    ex_store_data    = i.sd;
    ex_write_reg     = i.wr;
    ex_branch_target = i.tgt;
    ex_branch        = i.br;
    ex_mem_read      = i.mr;
    ex_mem_write     = i.mw;
    ex_reg_write     = i.rw;
    ex_mem_to_reg    = i.m2r;
  endtask

  task automatic modelReset();
    mem_slot  = nopInstr();
    mem_kill  = 1'b0;
    wb_slot   = nopInstr();
    wb_kill   = 1'b0;
    wb_loaded = 32'h0;
  endtask

  // One clock edge in instruction terms: the MEM instruction does its load
  // and store and retires into WB, and the new instruction enters MEM,
  // squashed if the one ahead of it was a taken branch.
  task automatic modelEdge(input instr_t n, input logic in_reset);
    logic [7:0]  idx;
    logic [31:0] loaded;
    logic        taken;
    if (in_reset) begin
      modelReset();
    end else begin
      idx    = mem_slot.alu[9:2];
      loaded = (mem_slot.mr && !mem_kill) ? mem_model[idx] : 32'h0;
      if (mem_slot.mw && !mem_kill) mem_model[idx] = mem_slot.sd;
      taken     = mem_slot.br && mem_slot.zero && !mem_kill;
      wb_slot   = mem_slot;
      wb_kill   = mem_kill;
      wb_loaded = loaded;
      mem_slot  = n;
      mem_kill  = taken;
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " mem_pcsrc"}, 32'(mem_pcsrc),
               32'(mem_slot.br & mem_slot.zero & ~mem_kill));
    checkValue({tag, " mem_branch_target"}, mem_branch_target, mem_slot.tgt);
    checkValue({tag, " mem_reg_write"}, 32'(mem_reg_write), 32'(mem_slot.rw & ~mem_kill));
    checkValue({tag, " mem_write_reg"}, 32'(mem_write_reg), 32'(mem_slot.wr));
    checkValue({tag, " mem_alu_result"}, mem_alu_result, mem_slot.alu);
    checkValue({tag, " wb_reg_write"}, 32'(wb_reg_write),
               32'(wb_slot.rw & ~wb_kill & (wb_slot.wr != 5'd0)));
    checkValue({tag, " wb_write_reg"}, 32'(wb_write_reg), 32'(wb_slot.wr));
    checkValue({tag, " wb_write_data"}, wb_write_data,
               wb_slot.m2r ? wb_loaded : wb_slot.alu);
  endtask

  // Drive one instruction from the falling edge, let the DUT capture it,
  // and leave time at the next falling edge for sampling.
  task automatic stepCycle(input instr_t i);
    applyStimulus(i);
    @(posedge clk);
    modelEdge(i, !rst);
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    rst = 1'b0;
    applyStimulus(nopInstr());

    // Reset held with random inputs: every output stays at zero
    $display("[TB] reset phase");
    #1;
    checkOutput("reset_async");
    for (int c = 0; c < 4; c++) begin
      stepCycle(randInstr());
      checkOutput("reset_hold");
    end

    // Release and follow two ALU instructions through MEM and WB
    rst = 1'b1;
    stepCycle(mkInstr(32'h0000_00AB, 1'b0, 32'h0, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    checkOutput("release_mem");
    checkValue("release_mem_alu", mem_alu_result, 32'h0000_00AB);
    stepCycle(mkInstr(32'h0000_00CD, 1'b0, 32'h0, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    checkOutput("release_wb");
    checkValue("release_wb_data", wb_write_data, 32'h0000_00AB);

    // Fill every word with a known pattern so later loads are defined
    for (int w = 0; w < 256; w++) begin
      stepCycle(mkInstr(32'(w) << 2, 1'b0, 32'hC0DE_0000 | 32'(w), 5'd0, 32'h0,
                        1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    stepCycle(nopInstr());
    stepCycle(nopInstr());

    // Directed instruction sequence; wb columns refer to the previous row
    //                alu           z     sd            wr     tgt         br    mr    mw    rw    m2r
    vecs[0]  = '{mkInstr(32'h1234, 1'b0, 32'h0,        5'd5,  32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 32'h0,  1'b0, 5'd0,  32'h0};
    vecs[1]  = '{mkInstr(32'h10,   1'b0, 32'hDEADBEEF, 5'd0,  32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 32'h0,  1'b1, 5'd5,  32'h1234};
    vecs[2]  = '{mkInstr(32'h10,   1'b0, 32'h0,        5'd8,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b0, 5'd0,  32'h10};
    vecs[3]  = '{mkInstr(32'h13,   1'b0, 32'h0,        5'd9,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b1, 5'd8,  32'hDEADBEEF};
    vecs[4]  = '{mkInstr(32'h400,  1'b0, 32'hA5A5A5A5, 5'd0,  32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 32'h0,  1'b1, 5'd9,  32'hDEADBEEF};
    vecs[5]  = '{mkInstr(32'h0,    1'b0, 32'h0,        5'd10, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b0, 5'd0,  32'h400};
    vecs[6]  = '{mkInstr(32'h0,    1'b1, 32'h0,        5'd0,  32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 32'h40, 1'b1, 5'd10, 32'hA5A5A5A5};
    vecs[7]  = '{mkInstr(32'h20,   1'b0, 32'h11111111, 5'd3,  32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, 32'h0,  1'b0, 5'd0,  32'h0};
    vecs[8]  = '{mkInstr(32'h20,   1'b0, 32'h0,        5'd4,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b0, 5'd3,  32'h20};
    vecs[9]  = '{mkInstr(32'h1,    1'b0, 32'h0,        5'd0,  32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 32'h80, 1'b1, 5'd4,  32'hC0DE0008};
    vecs[10] = '{mkInstr(32'h20,   1'b0, 32'h22222222, 5'd3,  32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0, 32'h0,  1'b0, 5'd0,  32'h1};
    vecs[11] = '{mkInstr(32'h20,   1'b0, 32'h0,        5'd6,  32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b1, 5'd3,  32'h20};
    vecs[12] = '{mkInstr(32'h7,    1'b0, 32'h0,        5'd0,  32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 32'h0,  1'b1, 5'd6,  32'h22222222};
    vecs[13] = '{nopInstr(),                                                                            1'b0, 32'h0,  1'b0, 5'd0,  32'h7};
    vecs[14] = '{mkInstr(32'h30,   1'b0, 32'h33333333, 5'd7,  32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0, 32'h0,  1'b0, 5'd0,  32'h0};
    vecs[15] = '{mkInstr(32'h30,   1'b0, 32'h0,        5'd11, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0, 32'h0,  1'b1, 5'd7,  32'hC0DE000C};
    vecs[16] = '{nopInstr(),                                                                            1'b0, 32'h0,  1'b1, 5'd11, 32'h33333333};

    $display("[TB] directed table phase");
    for (int r = 0; r < 17; r++) begin
      stepCycle(vecs[r].in);
      checkValue($sformatf("row%0d mem_pcsrc", r), 32'(mem_pcsrc), 32'(vecs[r].pcsrc));
      checkValue($sformatf("row%0d mem_branch_target", r), mem_branch_target, vecs[r].tgt);
      checkValue($sformatf("row%0d wb_reg_write", r), 32'(wb_reg_write), 32'(vecs[r].wb_rw));
      checkValue($sformatf("row%0d wb_write_reg", r), 32'(wb_write_reg), 32'(vecs[r].wb_wr));
      checkValue($sformatf("row%0d wb_write_data", r), wb_write_data, vecs[r].wb_data);
    end

    // Reset with a store and a register write in flight: neither completes
    $display("[TB] mid-run reset sequence");
    stepCycle(mkInstr(32'h44, 1'b0, 32'h0, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    stepCycle(mkInstr(32'h50, 1'b0, 32'h55555555, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_async");
    checkValue("midreset_wb_reg_write", 32'(wb_reg_write), 32'h0);
    stepCycle(nopInstr());
    rst = 1'b1;
    stepCycle(mkInstr(32'h50, 1'b0, 32'h0, 5'd13, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    stepCycle(nopInstr());
    checkValue("midreset_store_dropped", wb_write_data, 32'hC0DE0014);
    checkOutput("midreset_after");

    // Random instruction streams against the model
    $display("[TB] random phase");
    for (int c = 0; c < 1500; c++) begin
      if (rst && $urandom_range(0, 99) < 2) begin
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("rand_reset_async");
      end else if (!rst && $urandom_range(0, 2) == 0) begin
        rst = 1'b1;
      end
      stepCycle(randInstr());
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
